// File: rtl/mult_arbiter.sv
// Round-robin arbiter that time-shares one external multiplier among N_REQ requesters.
// One operation in flight; a WAIT-state watchdog aborts a multiplier that never answers.
module mult_arbiter #(
    parameter int N_REQ   = 3,
    parameter int W_OP    = 21,
    parameter int W_RES   = 45,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*W_OP-1:0]   req_a,
    input  logic [N_REQ*W_OP-1:0]   req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [W_RES-1:0]        rsp_result,
    output logic                    rsp_err,
    output logic                    mult_start,
    output logic [W_OP-1:0]         mult_a,
    output logic [W_OP-1:0]         mult_b,
    input  logic                    mult_done,
    input  logic [W_RES-1:0]        mult_result,
    output logic                    busy
);
    localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int W_CNT = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic [W_IDX-1:0]   rr_ptr, grant, pick;
    logic               found, can_grant;
    logic               rst_d;
    logic [W_CNT-1:0]   cnt;
    logic [W_RES-1:0]   result;
    logic               err;
    logic [W_OP-1:0]    op_a, op_b;

    // First asserted request at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = W_IDX'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // No grant while in reset or on the first cycle out of it.
    assign can_grant = (state == IDLE) && !rst && !rst_d && found;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (can_grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mult_done || cnt == W_CNT'(TIMEOUT - 1)) state_next = RESP;
            RESP:    if (rsp_ready[grant]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            rst_d  <= 1'b1;
        end else begin
            rst_d <= 1'b0;
            state <= state_next;
            case (state)
                IDLE: if (can_grant) begin
                    grant <= pick;
                    op_a  <= req_a[int'(pick)*W_OP +: W_OP];
                    op_b  <= req_b[int'(pick)*W_OP +: W_OP];
                end
                ISSUE: cnt <= '0;
                // cnt holds the number of WAIT cycles already spent; done on the last one still wins
                WAIT: begin
                    if (mult_done) begin
                        result <= mult_result;
                        err    <= 1'b0;
                    end else if (cnt == W_CNT'(TIMEOUT - 1)) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + W_CNT'(1);
                    end
                end
                RESP: if (rsp_ready[grant])
                    rr_ptr <= (grant == W_IDX'(N_REQ - 1)) ? '0 : grant + W_IDX'(1);
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet combinationally while rst is high.
    assign req_ready  = can_grant ? (N_REQ'(1) << pick) : '0;
    assign rsp_valid  = (!rst && state == RESP) ? (N_REQ'(1) << grant) : '0;
    assign rsp_result = result;
    assign rsp_err    = !rst && (state == RESP) && err;
    assign mult_start = !rst && (state == ISSUE);
    assign mult_a     = rst ? '0 : op_a;
    assign mult_b     = rst ? '0 : op_b;
    assign busy       = !rst && (state != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a behavioural multiplier with programmable latency,
// a reference round-robin pointer, and per-response checks of owner, result, error and latency.
module tb_mult_arbiter;
    localparam int N = 3, W = 21, WR = 45, TO = 15;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [WR-1:0]  rsp_result, mult_result;
    logic           rsp_err, mult_start, mult_done, busy;
    logic [W-1:0]   mult_a, mult_b;

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(N), .W_OP(W), .W_RES(WR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_result(mult_result), .busy(busy)
    );

    typedef struct {
        int             idx;
        logic [W-1:0]   a, b;
        logic [WR-1:0]  res;
        logic           err;
        int             lat;
    } exp_t;

    exp_t          sbq[$];
    int            glog[$];
    logic [WR-1:0] rlog[$];
    int            n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Multiplier model: done pulses lat cycles after mult_start; lat==0 never answers.
    int            lat = 5;
    int            cd = -1;
    logic [WR-1:0] mprod;
    always @(negedge clk) begin
        mult_done   = 1'b0;
        mult_result = {$urandom, $urandom};
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mult_done   = 1'b1;
                mult_result = mprod;
                cd          = -1;
            end
        end
        if (mult_start) begin
            mprod = WR'(mult_a) * WR'(mult_b);
            cd    = (lat == 0) ? -1 : lat;
        end
    end

    // Monitor and scoreboard
    int   tb_rr = 0, cyc = 0, start_cyc = 0, mg;
    logic rst_prev = 1'b1, pv = 1'b0, ps = 1'b0, e_err;
    exp_t me;
    always @(negedge clk) begin
        cyc++;
        if (rst || rst_prev) begin
            chk("reset_outs", {req_ready, rsp_valid, rsp_err, mult_start, mult_a, mult_b, busy}, 0);
            sbq.delete();
            tb_rr = 0;
            pv    = 1'b0;
        end else begin
            if (|req_ready) begin
                mg = pick(req_valid, tb_rr);
                chk("grant", req_ready, 64'(1) << mg);
                chk("accept_idle", busy, 0);
                e_err  = (lat == 0) || (lat > TO);
                me.idx = mg;
                me.a   = req_a[mg*W +: W];
                me.b   = req_b[mg*W +: W];
                me.res = e_err ? '0 : WR'(me.a) * WR'(me.b);
                me.err = e_err;
                me.lat = e_err ? TO + 1 : lat + 1;
                sbq.push_back(me);
                glog.push_back(mg);
            end
            if (mult_start) begin
                chk("start_pulse", ps, 0);
                start_cyc = cyc;
                if (sbq.size() == 0) chk("start_unexpected", mult_start, 0);
                else begin
                    chk("mult_a", mult_a, sbq[0].a);
                    chk("mult_b", mult_b, sbq[0].b);
                end
            end
            if (|rsp_valid) begin
                if (sbq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    me = sbq[0];
                    chk("rsp_owner", rsp_valid, 64'(1) << me.idx);
                    chk("rsp_result", rsp_result, me.res);
                    chk("rsp_err", rsp_err, me.err);
                    chk("rsp_busy", busy, 1);
                    if (!pv) chk("rsp_latency", cyc - start_cyc, me.lat);
                    if (|(rsp_valid & rsp_ready)) begin
                        void'(sbq.pop_front());
                        rlog.push_back(rsp_result);
                        tb_rr = (me.idx + 1) % N;
                        pv    = 1'b0;
                    end else pv = 1'b1;
                end
            end else pv = 1'b0;
        end
        ps       = mult_start;
        rst_prev = rst;
    end

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (glog.size() < n && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 300) chk("grant_wait_expired", 0, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sbq.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 300) chk("idle_wait_expired", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic one_op(input logic [N-1:0] m, input int l);
        lat = l;
        req_valid = m;
        wait_grants(glog.size() + 1);
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = '1; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request; operands changed right after acceptance must not matter
        set_ops(0, 2, 10);
        lat = 5;
        req_valid = 3'b001;
        wait_grants(1);
        req_valid = '0;
        set_ops(0, 7, 7);
        wait_idle();
        chk("single_result", rlog[rlog.size()-1], 20);

        // Contention from a fresh pointer
        do_reset();
        glog.delete(); rlog.delete();
        set_ops(0, 3, 11); set_ops(1, 4, 12); set_ops(2, 5, 13);
        lat = 3;
        req_valid = 3'b111;
        wait_grants(4);
        req_valid = '0;
        wait_idle();
        chk("order_0", glog[0], 0); chk("order_1", glog[1], 1);
        chk("order_2", glog[2], 2); chk("order_3", glog[3], 0);
        chk("cont_r0", rlog[0], 33); chk("cont_r1", rlog[1], 48); chk("cont_r2", rlog[2], 65);

        // Backpressure on requester 0; stray rsp_ready bits of others must be ignored
        set_ops(0, 6, 7); set_ops(1, 8, 9);
        lat = 3;
        rsp_ready = 3'b110;
        req_valid = 3'b001;
        wait_grants(glog.size() + 1);
        req_valid = 3'b010;
        begin
            int t = 0;
            while (!rsp_valid[0] && t < 100) begin @(posedge clk); #1; t++; end
            if (t >= 100) chk("bp_wait_expired", 0, 1);
        end
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_ready", req_ready, 0);
            chk("bp_valid", rsp_valid, 3'b001);
            chk("bp_result", rsp_result, 42);
        end
        @(posedge clk); #1 rsp_ready = '1;
        wait_grants(glog.size() + 1);
        req_valid = '0;
        wait_idle();
        chk("bp_next_grant", glog[glog.size()-1], 1);

        // Timeouts: never done, done on the last WAIT cycle, done one cycle too late
        set_ops(2, 100, 100);
        one_op(3'b100, 0);
        chk("to_result", rlog[rlog.size()-1], 0);
        set_ops(0, 9, 9);
        one_op(3'b001, TO);
        chk("to_edge_result", rlog[rlog.size()-1], 81);
        set_ops(1, 5, 5);
        one_op(3'b010, TO + 1);
        chk("to_late_result", rlog[rlog.size()-1], 0);

        // Reset two cycles into the operation, with the multiplier answering afterwards
        lat = 8;
        req_valid = 3'b100;
        wait_grants(glog.size() + 1);
        req_valid = '0;
        begin
            int t = 0;
            while (!mult_start && t < 20) begin @(posedge clk); #1; t++; end
            if (t >= 20) chk("start_wait_expired", 0, 1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_quiet", {busy, rsp_valid, rsp_err, mult_start}, 0);
        end
        @(posedge clk); #1;
        glog.delete();
        set_ops(0, 1, 1); set_ops(1, 1, 1); set_ops(2, 1, 1);
        lat = 2;
        req_valid = 3'b111;
        wait_grants(1);
        req_valid = '0;
        wait_idle();
        chk("post_rst_grant", glog[0], 0);

        // Full-width operands
        set_ops(0, '1, '1);
        one_op(3'b001, 2);
        chk("max_result", rlog[rlog.size()-1], 45'd4398042316801);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
